// File: rtl/fwd_hazard_unit_pkg.sv
// Shared select codes, register-address width and in-flight slot record layout.
// The EX operand muxes decode the same sel_e constants.
package fwd_hazard_unit_pkg;

  localparam int unsigned RA_W = 3;

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_EXM = 2'b01,
    SEL_MWB = 2'b10,
    SEL_LD  = 2'b11
  } sel_e;

  typedef struct packed {
    logic            vld;
    logic [RA_W-1:0] rd;
    logic            wr;
    logic            ld;
  } slot_t;

  // r0 is hardwired zero, so it never has a producer.
  function automatic logic slot_match(input logic [RA_W-1:0] rs, input slot_t s);
    return s.vld & s.wr & (s.rd == rs) & (rs != '0);
  endfunction

endpackage

// File: rtl/fwd_src_cmp.sv
// One source address against the EX/MEM slot records: operand select plus hazard flag.
// FWD_HAZARD_FORWARDING_EN selects forwarding; otherwise a full interlock.
module fwd_src_cmp
  import fwd_hazard_unit_pkg::*;
(
  input  logic [RA_W-1:0] rs,
  input  slot_t           ex_slot,
  input  slot_t           mem_slot,
  output sel_e            sel,
  output logic            hazard
);

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    ex_hit  = slot_match(rs, ex_slot);
    mem_hit = slot_match(rs, mem_slot);
    sel     = SEL_RF;
`ifdef FWD_HAZARD_FORWARDING_EN
    // Youngest producer first; a load in EX cannot forward and raises the hazard.
    if (ex_hit && !ex_slot.ld) begin
      sel = SEL_EXM;
    end else if (mem_hit) begin
      sel = mem_slot.ld ? SEL_LD : SEL_MWB;
    end
    hazard = ex_hit & ex_slot.ld;
`else
    hazard = ex_hit | mem_hit;
`endif
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding/interlock controller for the ID->EX->MEM->WB pipeline.
// FWD_HAZARD_FORWARDING_EN enables forwarding; without it the unit fully interlocks.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic [CNT_W-1:0] stall_cnt
);

  // WB needs no record: the regfile writes through, so a WB hit reads the regfile.
  slot_t            ex_q, ex_d;
  slot_t            mem_q, mem_d;
  sel_e             sel_a_q, sel_a_d;
  sel_e             sel_b_q, sel_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  sel_e cmp_sel_a, cmp_sel_b;
  logic haz_a, haz_b;
  logic issue;

  fwd_src_cmp u_cmp_a (
    .rs       (id_rs1),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .sel      (cmp_sel_a),
    .hazard   (haz_a)
  );

  fwd_src_cmp u_cmp_b (
    .rs       (id_rs2),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .sel      (cmp_sel_b),
    .hazard   (haz_b)
  );

  always_comb begin
    stall       = id_valid & ~flush & (haz_a | haz_b);
    issue       = id_valid & ~stall & ~flush;
    ex_d        = '0;
    sel_a_d     = SEL_RF;
    sel_b_d     = SEL_RF;
    if (issue) begin
      ex_d    = '{vld: 1'b1, rd: id_rd, wr: id_wr_en, ld: id_is_load};
      sel_a_d = cmp_sel_a;
      sel_b_d = cmp_sel_b;
    end
    mem_d       = ex_q;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      sel_a_q     <= SEL_RF;
      sel_b_q     <= SEL_RF;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sel_a     = sel_a_q;
  assign sel_b     = sel_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit; expectations follow FWD_HAZARD_FORWARDING_EN.
module tb_fwd_hazard_unit;

`ifdef FWD_HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int unsigned CW = 3;
  localparam int CNT_MAX = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [2:0]    id_rs1, id_rs2, id_rd;
  logic          id_wr_en, id_is_load, flush;
  logic          stall;
  logic [1:0]    sel_a, sel_b;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  int s;

  fwd_hazard_unit #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .id_wr_en   (id_wr_en),
    .id_is_load (id_is_load),
    .flush      (flush),
    .stall      (stall),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int pick(input int f, input int i);
    return FWD ? f : i;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic add_stalls(input int n);
    for (int i = 0; i < n; i++) if (exp_cnt < CNT_MAX) exp_cnt++;
  endtask

  task automatic drive(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, input logic wr, input logic ld, input logic fl);
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_wr_en = wr; id_is_load = ld; flush = fl;
    #1;
  endtask

  task automatic bubble();
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Holds the instruction in ID while stall is high; counts stalled cycles.
  task automatic send(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                      input logic ld, output int stalls);
    drive(1'b1, rs1, rs2, rd, 1'b1, ld, 1'b0);
    stalls = 0;
    while (stall === 1'b1 && stalls < 8) begin
      stalls++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; id_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_wr_en = 1'b0; id_is_load = 1'b0; flush = 1'b0;
    do_reset();

    for (int c = 0; c < 3; c++) begin
      bubble();
      chk("rst_sel_a", sel_a, 0);
      chk("rst_sel_b", sel_b, 0);
      chk("rst_stall", stall, 0);
      chk("rst_cnt", stall_cnt, 0);
    end

    // ADD r1,r2,r3 ; ADD r2,r1,r3
    send(3'd2, 3'd3, 3'd1, 1'b0, s);
    send(3'd1, 3'd3, 3'd2, 1'b0, s);
    chk("t2_stalls", s, pick(0, 2));
    add_stalls(pick(0, 2));
    bubble();
    chk("t2_sel_a", sel_a, pick(1, 0));
    chk("t2_sel_b", sel_b, 0);
    chk("t2_cnt", stall_cnt, exp_cnt);
    repeat (3) bubble();

    // ADD r1 ; NOP ; SUB r4,r5,r1
    send(3'd2, 3'd3, 3'd1, 1'b0, s);
    bubble();
    send(3'd5, 3'd1, 3'd4, 1'b0, s);
    chk("t3_stalls", s, pick(0, 1));
    add_stalls(pick(0, 1));
    bubble();
    chk("t3_sel_a", sel_a, 0);
    chk("t3_sel_b", sel_b, pick(2, 0));
    chk("t3_cnt", stall_cnt, exp_cnt);
    repeat (3) bubble();

    // LD r2 ; ADD r3,r2,r2 from a fresh reset
    do_reset();
    send(3'd0, 3'd0, 3'd2, 1'b1, s);
    chk("t4_ld_stalls", s, 0);
    send(3'd2, 3'd2, 3'd3, 1'b0, s);
    chk("t4_stalls", s, pick(1, 2));
    add_stalls(pick(1, 2));
    bubble();
    chk("t4_sel_a", sel_a, pick(3, 0));
    chk("t4_sel_b", sel_b, pick(3, 0));
    chk("t4_cnt", stall_cnt, exp_cnt);
    repeat (3) bubble();

    // Write r0 then read r0
    send(3'd2, 3'd3, 3'd0, 1'b0, s);
    send(3'd0, 3'd0, 3'd5, 1'b0, s);
    chk("t5_r0_stalls", s, 0);
    bubble();
    chk("t5_r0_sel_a", sel_a, 0);
    chk("t5_r0_sel_b", sel_b, 0);
    repeat (3) bubble();

    // LD r1 ; ADD r1,r2,r3 ; ADD r6,r1,r1 -> younger ALU producer wins
    send(3'd0, 3'd0, 3'd1, 1'b1, s);
    send(3'd2, 3'd3, 3'd1, 1'b0, s);
    chk("t5_y_first_stalls", s, 0);
    send(3'd1, 3'd1, 3'd6, 1'b0, s);
    chk("t5_y_stalls", s, pick(0, 2));
    add_stalls(pick(0, 2));
    bubble();
    chk("t5_y_sel_a", sel_a, pick(1, 0));
    chk("t5_y_sel_b", sel_b, pick(1, 0));
    chk("t5_y_cnt", stall_cnt, exp_cnt);
    repeat (3) bubble();

    // LD r2 ; ADD r3,r2,r2 flushed in the load-use cycle
    send(3'd0, 3'd0, 3'd2, 1'b1, s);
    drive(1'b1, 3'd2, 3'd2, 3'd3, 1'b1, 1'b0, 1'b1);
    chk("t6_flush_stall", stall, 0);
    bubble();
    chk("t6_sel_a", sel_a, 0);
    chk("t6_sel_b", sel_b, 0);
    send(3'd3, 3'd0, 3'd7, 1'b0, s);
    chk("t6_after_stalls", s, 0);
    bubble();
    chk("t6_after_sel_a", sel_a, 0);
    chk("t6_cnt", stall_cnt, exp_cnt);
    repeat (3) bubble();

    // Reset asserted while a load-use stall is pending
    send(3'd0, 3'd0, 3'd2, 1'b1, s);
    drive(1'b1, 3'd2, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0);
    chk("rms_stall_before", stall, 1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rms_stall_after", stall, 0);
    chk("rms_cnt", stall_cnt, 0);
    chk("rms_sel_a", sel_a, 0);
    reset = 1'b0;
    exp_cnt = 0;
    repeat (3) bubble();

    // Repeated load-use pairs drive the counter into saturation
    for (int k = 0; k < 8; k++) begin
      send(3'd0, 3'd0, 3'd2, 1'b1, s);
      send(3'd2, 3'd2, 3'd3, 1'b0, s);
      chk("sat_stalls", s, pick(1, 2));
      add_stalls(pick(1, 2));
      bubble();
      chk("sat_cnt", stall_cnt, exp_cnt);
      repeat (2) bubble();
    end
    chk("sat_final", stall_cnt, CNT_MAX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
